// File: rtl/trace_pkg.sv
// Shared types for the execution trace monitor: FSM states, the trace entry
// layout and the register-index width helper.
package trace_pkg;

    localparam int XLEN_D     = 32;
    localparam int NUM_REGS_D = 32;
    localparam int CNT_W_D    = 16;

    function automatic int reg_idx_w(input int n);
        return $clog2(n);
    endfunction

    localparam int REG_IDX_W = reg_idx_w(NUM_REGS_D);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W_D-1:0]   cycle;
        logic [XLEN_D-1:0]    pc;
        logic                 wb;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN_D-1:0]    data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is still accepted
// when the head is popped in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             accept_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign empty_o  = (r_count == {(AW+1){1'b0}});
    assign full_o   = (r_count == (AW+1)'(DEPTH));
    assign w_pop    = pop_i & ~empty_o;
    assign w_push   = push_i & (~full_o | w_pop);
    assign accept_o = w_push;
    assign data_o   = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; memory is cleared so outputs read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/trace_monitor.sv
// Per-cycle execution trace unit: stamps PC and writeback into a bounded FIFO,
// keeps a shadow register file and streams it out on request.
module trace_monitor
    import trace_pkg::*;
#(
    parameter int XLEN       = XLEN_D,
    parameter int NUM_REGS   = NUM_REGS_D,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = CNT_W_D,
    parameter int MAX_CYCLES = 30
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [XLEN-1:0]             pc_i,
    input  logic                        wb_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd_i,
    input  logic [XLEN-1:0]             wb_data_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [CNT_W-1:0]            trace_cycle_o,
    output logic [XLEN-1:0]             trace_pc_o,
    output logic                        trace_wb_o,
    output logic [$clog2(NUM_REGS)-1:0] trace_rd_o,
    output logic [XLEN-1:0]             trace_data_o,
    input  logic                        dump_req_i,
    output logic                        dump_valid_o,
    input  logic                        dump_ready_i,
    output logic [$clog2(NUM_REGS)-1:0] dump_idx_o,
    output logic [XLEN-1:0]             dump_data_o,
    output logic                        running_o,
    output logic                        done_o,
    output logic                        overflow_o,
    output logic [CNT_W-1:0]            drop_cnt_o
);
    localparam int                RW         = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [RW-1:0]     LAST_IDX   = RW'(NUM_REGS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;
    logic [RW-1:0]    r_dump_idx;
    logic [XLEN-1:0]  r_shadow [NUM_REGS];

    trace_entry_t     w_entry;
    trace_entry_t     w_head;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;
    logic             w_real_wb;

    assign w_push    = (r_state == ST_RUN);
    assign w_real_wb = wb_en_i && (wb_rd_i != {RW{1'b0}});
    assign w_drop    = w_push & ~w_accept;

    // Assemble the entry captured this cycle; data is zeroed when nothing was written.
    always_comb begin
        w_entry       = '0;
        w_entry.cycle = r_cycle;
        w_entry.pc    = pc_i;
        w_entry.wb    = w_real_wb;
        w_entry.rd    = wb_rd_i;
        if (wb_en_i) begin
            w_entry.data = wb_data_i;
        end else begin
            w_entry.data = {XLEN{1'b0}};
        end
    end

    trace_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (w_push),
        .pop_i    (trace_ready_i),
        .data_i   (w_entry),
        .data_o   (w_head),
        .empty_o  (w_empty),
        .full_o   (w_full),
        .accept_o (w_accept)
    );

    // Capture/dump sequencing; MAX_CYCLES of 0 keeps capture running forever.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_cycle    <= {CNT_W{1'b0}};
            r_dump_idx <= {RW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_cycle <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_cycle <= r_cycle + {{(CNT_W-1){1'b0}}, 1'b1};
                    if ((MAX_CYCLES != 0) && (r_cycle == LAST_CYCLE)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (dump_req_i) begin
                        r_state    <= ST_DUMP;
                        r_dump_idx <= {RW{1'b0}};
                    end
                end
                ST_DUMP: begin
                    if (dump_ready_i) begin
                        if (r_dump_idx == LAST_IDX) begin
                            r_state    <= ST_DONE;
                            r_dump_idx <= {RW{1'b0}};
                        end else begin
                            r_dump_idx <= r_dump_idx + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= {CNT_W{1'b0}};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Shadow register file; x0 is never written so it always reads 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= {XLEN{1'b0}};
            end
        end else if (w_push && w_real_wb) begin
            r_shadow[wb_rd_i] <= wb_data_i;
        end
    end

    assign trace_valid_o = ~w_empty;
    assign trace_cycle_o = w_head.cycle;
    assign trace_pc_o    = w_head.pc;
    assign trace_wb_o    = w_head.wb;
    assign trace_rd_o    = w_head.rd;
    assign trace_data_o  = w_head.data;
    assign dump_valid_o  = (r_state == ST_DUMP);
    assign dump_idx_o    = r_dump_idx;
    assign dump_data_o   = r_shadow[r_dump_idx];
    assign running_o     = (r_state == ST_RUN);
    assign done_o        = (r_state == ST_DONE) || (r_state == ST_DUMP);
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard bench for trace_monitor: a queue-based reference model predicts
// trace entries and dump beats, and negedge monitors compare what the DUT presents.
module tb_trace_monitor;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int MAXC  = 30;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [XLEN-1:0]   pc_i = '0;
    logic              wb_en_i = 1'b0;
    logic [4:0]        wb_rd_i = '0;
    logic [XLEN-1:0]   wb_data_i = '0;
    logic              trace_valid_o;
    logic              trace_ready_i = 1'b0;
    logic [CNT_W-1:0]  trace_cycle_o;
    logic [XLEN-1:0]   trace_pc_o;
    logic              trace_wb_o;
    logic [4:0]        trace_rd_o;
    logic [XLEN-1:0]   trace_data_o;
    logic              dump_req_i = 1'b0;
    logic              dump_valid_o;
    logic              dump_ready_i = 1'b0;
    logic [4:0]        dump_idx_o;
    logic [XLEN-1:0]   dump_data_o;
    logic              running_o;
    logic              done_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    trace_monitor #(.XLEN(XLEN), .NUM_REGS(NREGS), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i), .wb_en_i(wb_en_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_cycle_o(trace_cycle_o), .trace_pc_o(trace_pc_o),
        .trace_wb_o(trace_wb_o), .trace_rd_o(trace_rd_o), .trace_data_o(trace_data_o),
        .dump_req_i(dump_req_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
        .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .running_o(running_o),
        .done_o(done_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cyc;
        logic [XLEN-1:0]  pc;
        logic             wb;
        logic [4:0]       rd;
        logic [XLEN-1:0]  data;
    } exp_t;
    typedef struct {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
    } beat_t;

    exp_t  exp_q[$];
    beat_t dump_q[$];

    // Reference model: 0 idle, 1 run, 2 done, 3 dump
    int              mstate;
    int              mcyc;
    int              occ;
    int              mdrop;
    bit              movf;
    int              mbeat;
    logic [XLEN-1:0] mshadow [NREGS];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mstate = 0; mcyc = 0; occ = 0; mdrop = 0; movf = 1'b0; mbeat = 0;
        for (int i = 0; i < NREGS; i++) mshadow[i] = '0;
        exp_q.delete();
        dump_q.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {trace_valid_o, trace_cycle_o, trace_pc_o, trace_wb_o, trace_rd_o, trace_data_o,
                   dump_valid_o, dump_idx_o, dump_data_o, running_o, done_o, overflow_o, drop_cnt_o}, 160'd0);
    endtask

    // Predict the effect of the coming clock edge from the driven inputs, then advance.
    task automatic step();
        bit   pop;
        exp_t e;
        pop = trace_ready_i && (occ > 0);
        case (mstate)
            0: if (start_i) begin mstate = 1; mcyc = 0; end
            1: begin
                e.cyc  = mcyc[CNT_W-1:0];
                e.pc   = pc_i;
                e.wb   = wb_en_i && (wb_rd_i != 5'd0);
                e.rd   = wb_rd_i;
                e.data = wb_en_i ? wb_data_i : 32'd0;
                if (occ < DEPTH || pop) begin
                    exp_q.push_back(e);
                    occ++;
                end else begin
                    movf = 1'b1;
                    if (mdrop < 65535) mdrop++;
                end
                if (e.wb) mshadow[wb_rd_i] = wb_data_i;
                if (mcyc == MAXC - 1) mstate = 2;
                mcyc = (mcyc + 1) % 65536;
            end
            2: if (dump_req_i) begin
                mstate = 3;
                mbeat  = 0;
                for (int i = 0; i < NREGS; i++) dump_q.push_back('{i[4:0], mshadow[i]});
            end
            3: if (dump_ready_i) begin
                mbeat++;
                if (mbeat == NREGS) mstate = 2;
            end
            default: mstate = 0;
        endcase
        if (pop) occ--;
        @(posedge clk);
        #1;
        chk("running", running_o, mstate == 1);
        chk("done", done_o, mstate >= 2);
        chk("dump_valid", dump_valid_o, mstate == 3);
        chk("trace_valid", trace_valid_o, occ > 0);
        chk("drop_cnt", drop_cnt_o, mdrop[CNT_W-1:0]);
        chk("overflow", overflow_o, movf);
    endtask

    // Trace monitor: every accepted head must match the oldest predicted entry.
    always @(negedge clk) begin
        exp_t  e;
        beat_t b;
        if (rst_i && trace_valid_o && trace_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("trace_unexpected", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("trace_cycle", trace_cycle_o, e.cyc);
                chk("trace_pc", trace_pc_o, e.pc);
                chk("trace_wb", trace_wb_o, e.wb);
                chk("trace_rd", trace_rd_o, e.rd);
                chk("trace_data", trace_data_o, e.data);
            end
        end
        if (rst_i && dump_valid_o && dump_ready_i) begin
            if (dump_q.size() == 0) begin
                chk("dump_unexpected", 1'b1, 1'b0);
            end else begin
                b = dump_q.pop_front();
                chk("dump_idx", dump_idx_o, b.idx);
                chk("dump_data", dump_data_o, b.data);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst_i = 1'b1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic rand_wb(input bit avoid_x5);
        wb_en_i   = 1'($urandom_range(0, 1));
        wb_rd_i   = 5'($urandom_range(0, 31));
        wb_data_i = $urandom;
        if (avoid_x5 && wb_rd_i == 5'd5) wb_rd_i = 5'd6;
    endtask

    // mode 0: ready toggles, 1: always ready, 2: random ready
    task automatic do_dump(input int mode);
        dump_ready_i = 1'b0;
        dump_req_i   = 1'b1;
        step();
        dump_req_i = 1'b0;
        for (int k = 0; k < 200 && mstate == 3; k++) begin
            dump_ready_i = (mode == 0) ? ((k % 2) == 0) : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        dump_ready_i = 1'b0;
        chk("dump_all_beats_seen", dump_q.size(), 0);
        chk("dump_back_to_done", {done_o, dump_valid_o}, 2'b10);
    endtask

    task automatic drain(input bit rnd);
        for (int k = 0; k < 300 && occ > 0; k++) begin
            trace_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        chk("drain_all_entries_seen", exp_q.size(), 0);
        chk("drain_empty", trace_valid_o, 1'b0);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Full capture with ready held high and a known x5 write.
        trace_ready_i = 1'b1;
        do_start();
        for (int k = 0; k < MAXC; k++) begin
            pc_i = 32'(4 * k);
            if (k == 3) begin
                wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD;
            end else if (k == 4) begin
                wb_en_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'd7;
            end else begin
                rand_wb(1'b1);
            end
            step();
        end
        wb_en_i = 1'b0;
        chk("t1_done_after_budget", done_o, 1'b1);
        chk("t1_no_drops", drop_cnt_o, 16'd0);
        drain(1'b0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        do_dump(0);
        do_dump(2);

        // Reset asynchronously in the middle of a dump, at beat 10.
        dump_req_i = 1'b1;
        step();
        dump_req_i   = 1'b0;
        dump_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("t2_beat10_presented", dump_idx_o, 5'd10);
        #2;
        rst_i = 1'b0;
        #1;
        chk_all_zero("async_reset_mid_dump");
        dump_ready_i = 1'b0;
        do_reset();

        // Consumer stalled for the whole capture: FIFO fills, the rest drop.
        trace_ready_i = 1'b0;
        do_start();
        for (int k = 0; k < MAXC; k++) begin
            pc_i = $urandom;
            wb_en_i = 1'b0; wb_rd_i = 5'($urandom_range(0, 31)); wb_data_i = $urandom;
            step();
        end
        chk("t2_drop_cnt_14", drop_cnt_o, 16'd14);
        chk("t2_overflow", overflow_o, 1'b1);
        drain(1'b1);
        do_dump(1);

        // Fill, drop four, then pop while full so later pushes survive.
        do_reset();
        do_start();
        for (int k = 0; k < MAXC; k++) begin
            trace_ready_i = (k >= 20);
            pc_i = $urandom;
            rand_wb(1'b0);
            step();
        end
        wb_en_i = 1'b0;
        chk("t3_drop_cnt_4", drop_cnt_o, 16'd4);
        drain(1'b0);
        do_dump(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/trace_monitor.md
Name: trace_monitor

Overview:
Synthesizable per-cycle execution trace unit for the single-cycle RISC-V CPU. It taps the fetch PC and the register-file writeback port, and time-stamps each cycle into a bounded trace FIFO. It keeps a shadow copy of the architectural registers and stops capture after a programmable cycle budget. On request it streams a full register dump, so the CPU can be checked in simulation, on FPGA or from a host without hierarchical probes.

Parameters:
XLEN, 32, data/PC width
NUM_REGS, 32, architectural registers (power of two)
DEPTH, 16, trace FIFO entries (power of two, >=2)
CNT_W, 16, cycle-counter and drop-counter width
MAX_CYCLES, 30, capture budget in RUN cycles; 0 = unlimited

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
start_i  in  1  begin capture (sampled in IDLE only)
pc_i  in  XLEN  current PC
wb_en_i  in  1  register write enable
wb_rd_i  in  log2(NUM_REGS)  destination register
wb_data_i  in  XLEN  writeback data
trace_valid_o  out  1  FIFO head valid
trace_ready_i  in  1  consumer pops head when valid&ready
trace_cycle_o  out  CNT_W  cycle stamp of head
trace_pc_o  out  XLEN  PC of head
trace_wb_o  out  1  head carried a real write (rd!=0)
trace_rd_o  out  log2(NUM_REGS)  head destination
trace_data_o  out  XLEN  head write data
dump_req_i  in  1  request register dump (honoured in DONE only)
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump beat accepted
dump_idx_o  out  log2(NUM_REGS)  register index of beat
dump_data_o  out  XLEN  shadow register value
running_o  out  1  state==RUN
done_o  out  1  state==DONE or DUMP
overflow_o  out  1  sticky: at least one entry dropped
drop_cnt_o  out  CNT_W  dropped entries, saturating

Behaviour:
- Reset (async, rst_i=0): state IDLE; FIFO empty; cycle counter, drop_cnt, overflow, dump index = 0; shadow registers = 0; every output = 0.
- States: IDLE -> RUN on start_i=1 at posedge. RUN -> DONE after the push in the cycle whose stamp equals MAX_CYCLES-1; with MAX_CYCLES=0 it stays in RUN. DONE -> DUMP on dump_req_i=1. DUMP -> DONE after beat NUM_REGS-1 is accepted. start_i is ignored outside IDLE; only reset leaves DONE.
- RUN capture: every RUN cycle pushes one entry {cycle, pc_i, wb_en_i&&(wb_rd_i!=0), wb_rd_i, wb_en_i?wb_data_i:0}. The cycle stamp starts at 0 and increments by 1 per RUN cycle, wrapping at 2^CNT_W.
- Latency: an entry pushed at posedge n is visible on trace_* from n+1. Outputs come straight from FIFO registers, first-word fall-through.
- FIFO full without a pop in the same cycle: the entry is dropped, overflow_o is set (sticky), and drop_cnt_o increments, saturating at all-ones. Full with a pop in the same cycle: push is accepted and the count is unchanged.
- Empty: trace_valid_o=0, and trace_* data holds its last value (don't-care).
- The FIFO stays readable in every state; draining in DONE/DUMP is legal.
- Shadow regfile: in RUN, on wb_en_i and rd!=0, the shadow register takes wb_data_i at the posedge. x0 always reads 0. Writes outside RUN are ignored.
- DUMP: beats run in order idx 0..NUM_REGS-1. A beat advances only on dump_valid_o&dump_ready_i. dump_valid_o=1 throughout DUMP. Data is the shadow value at idx.
- Reset mid-RUN or mid-DUMP aborts immediately to IDLE with all state cleared.

Decomposition:
- Package trace_pkg holds the state enum (IDLE, RUN, DONE, DUMP), the trace entry struct (cycle, pc, wb, rd, data), and the REG_IDX_W=$clog2(NUM_REGS) helper.
- Sub-module trace_fifo: parametrised synchronous FIFO (width=entry, DEPTH), with full/empty, push/pop, and simultaneous push+pop when full.

Test Plan:
- Reset, start_i=1 for 1 cycle, trace_ready_i=1, MAX_CYCLES=30, pc_i=0,4,8,... -> 30 entries, cycles 0..29, trace_pc_o=4*cycle; done_o=1 after entry 29; drop_cnt_o=0.
- wb_en_i=1, rd=5, data=0xDEAD at cycle 3, then rd=0, data=7 at cycle 4 -> entry 3 has wb=1, rd=5, data=0xDEAD; entry 4 has wb=0. The dump then gives x5=0xDEAD and x0=0.
- trace_ready_i=0 throughout, DEPTH=16, MAX_CYCLES=30 -> 16 entries retained (cycles 0..15), drop_cnt_o=14, overflow_o=1. Draining yields cycles 0..15 in order.
- FIFO full plus pop in the same cycle -> no drop, count stays 16, drop_cnt_o unchanged.
- In DONE, dump_req_i=1, dump_ready_i toggling 1/0 -> 32 beats idx 0..31, no skips or repeats; then done_o=1 and state DONE. A second dump_req_i repeats the dump.
- rst_i=0 asserted during DUMP beat 10 -> all outputs 0 immediately (asynchronously); a new start_i restarts at cycle stamp 0 with shadow registers cleared.
